// File: rtl/dmem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_if : request/response bundle for the pipeline (P) and debug (D) ports
//           of dmem_arbiter.                                      Rev 1.0
// ----------------------------------------------------------------------------
interface dmem_if;
  logic        p_req;
  logic        p_we;
  logic [63:0] p_addr;
  logic [63:0] p_wdata;
  logic [63:0] p_rdata;
  logic        p_done;
  logic        p_stall;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_done;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    output p_rdata, p_done, p_stall,
    output d_rdata, d_done
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output d_req, d_we, d_addr, d_wdata,
    input  p_rdata, p_done, p_stall,
    input  d_rdata, d_done
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter : 64-bit data memory shared by the MEM stage and a debug port,
//                fixed-latency access sequencing with starvation guard. Rev 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  dmem_if.slave     bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 1 = debug port owns the access
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [63:0]   p_rdata_q, p_rdata_d;
  logic [63:0]   d_rdata_q, d_rdata_d;
  logic [63:0]   mem_q [DEPTH];

  logic starved;
  logic grant_p;
  logic grant_d;
  logic commit;
  logic p_done;
  logic d_done;
  logic unused_addr_bits;

  assign starved = (starve_q == SW'(MAX_WAIT));
  assign grant_p = bus.p_req & (~bus.d_req | ~starved);
  assign grant_d = bus.d_req & ~grant_p;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    commit    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Any idle cycle without a pending D request forgives its history.
        starve_d = '0;
        if (grant_p) begin
          owner_d = 1'b0;
          we_d    = bus.p_we;
          idx_d   = bus.p_addr[AW+2:3];
          wdata_d = bus.p_wdata;
          // grant_p with d_req set implies starve_q < MAX_WAIT, so no overflow.
          if (bus.d_req) starve_d = starve_q + 1'b1;
        end else if (grant_d) begin
          owner_d = 1'b1;
          we_d    = bus.d_we;
          idx_d   = bus.d_addr[AW+2:3];
          wdata_d = bus.d_wdata;
        end
        if (grant_p || grant_d) begin
          cnt_d   = CW'(LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    if (commit && !we_q) begin
      if (owner_q) d_rdata_d = mem_q[idx_q];
      else         p_rdata_d = mem_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Array is deliberately outside the reset domain; reset forces IDLE so no commit.
  always_ff @(posedge clk) begin
    if (commit && we_q) mem_q[idx_q] <= wdata_q;
  end

  assign p_done = (state_q == S_DONE) & ~owner_q;
  assign d_done = (state_q == S_DONE) &  owner_q;

  assign bus.p_done  = p_done;
  assign bus.d_done  = d_done;
  assign bus.p_rdata = p_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.p_stall = bus.p_req & ~p_done;

  assign unused_addr_bits = ^{bus.p_addr[63:AW+3], bus.p_addr[2:0],
                              bus.d_addr[63:AW+3], bus.d_addr[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : directed + randomized bench for dmem_arbiter against a
//                   timestamp-based transaction model.             Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DEPTH    = 256;
  localparam int AW       = 8;
  localparam int LAT      = 2;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_if bus ();

  dmem_arbiter #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .LAT      (LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant sampled at edge n commits at edge n+LAT,
  // done is visible for the following cycle, next grant no earlier than n+LAT+2.
  logic [63:0] mm [DEPTH];
  bit          mv [DEPTH];
  longint      m_edge = 0;
  longint      m_commit_at = 0;
  longint      m_free_at = 0;
  bit          m_active = 0;
  bit          m_is_d, m_we;
  int          m_idx;
  logic [63:0] m_wd;
  int          m_starve = 0;
  bit          exp_p_done = 0, exp_d_done = 0;
  logic [63:0] exp_p_rdata = '0, exp_d_rdata = '0;
  bit          exp_p_known = 1, exp_d_known = 1;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active    = 0;
        m_free_at   = 0;
        m_starve    = 0;
        exp_p_done  = 0;
        exp_d_done  = 0;
        exp_p_rdata = '0;
        exp_d_rdata = '0;
        exp_p_known = 1;
        exp_d_known = 1;
      end else begin
        m_edge++;
        exp_p_done = 0;
        exp_d_done = 0;
        if (m_active && m_edge == m_commit_at) begin
          m_active = 0;
          if (m_we) begin
            mm[m_idx] = m_wd;
            mv[m_idx] = 1;
          end else if (m_is_d) begin
            exp_d_rdata = mm[m_idx];
            exp_d_known = mv[m_idx];
          end else begin
            exp_p_rdata = mm[m_idx];
            exp_p_known = mv[m_idx];
          end
          if (m_is_d) exp_d_done = 1;
          else        exp_p_done = 1;
        end
        if (!m_active && m_edge >= m_free_at) begin
          if (bus.p_req && (!bus.d_req || m_starve < MAX_WAIT)) begin
            m_is_d   = 0;
            m_we     = bus.p_we;
            m_idx    = int'((bus.p_addr >> 3) % DEPTH);
            m_wd     = bus.p_wdata;
            m_starve = bus.d_req ? ((m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1) : 0;
            m_active = 1;
          end else if (bus.d_req) begin
            m_is_d   = 1;
            m_we     = bus.d_we;
            m_idx    = int'((bus.d_addr >> 3) % DEPTH);
            m_wd     = bus.d_wdata;
            m_starve = 0;
            m_active = 1;
          end else begin
            m_starve = 0;
          end
          if (m_active) begin
            m_commit_at = m_edge + LAT;
            m_free_at   = m_edge + LAT + 2;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      chk("p_done", 64'(bus.p_done), 64'(exp_p_done));
      chk("d_done", 64'(bus.d_done), 64'(exp_d_done));
      chk("p_stall", 64'(bus.p_stall), 64'(bus.p_req & ~exp_p_done));
      if (exp_p_known) chk("p_rdata", bus.p_rdata, exp_p_rdata);
      if (exp_d_known) chk("d_rdata", bus.d_rdata, exp_d_rdata);
    end
  end

  task automatic set_port(input bit is_d, input bit req, input bit we,
                          input logic [63:0] addr, input logic [63:0] wd);
    if (is_d) begin
      bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.p_req = req; bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wd;
    end
  endtask

  // One access from an idle controller; returns read data, edges to done, stall cycles.
  task automatic op(input string tag, input bit is_d, input bit we,
                    input logic [63:0] addr, input logic [63:0] wd, input int drop_after,
                    output logic [63:0] rd, output int lat, output int stall);
    bit done;
    @(negedge clk);
    set_port(is_d, 1'b1, we, addr, wd);
    #1;
    stall = (!is_d && bus.p_stall) ? 1 : 0;
    lat   = 0;
    done  = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
      if (lat == drop_after) begin
        if (is_d) bus.d_req = 1'b0;
        else      bus.p_req = 1'b0;
      end
      done = is_d ? bus.d_done : bus.p_done;
      if (!is_d && bus.p_stall) stall++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    rd = is_d ? bus.d_rdata : bus.p_rdata;
    @(negedge clk);
    set_port(is_d, 1'b0, we, addr, wd);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[AW+2:3] = ($urandom_range(0, 9) == 9) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic drive_rand(input bit is_d, input int ncyc);
    bit busy = 0;
    bit got  = 0;
    int held = 0;
    for (int c = 0; (c < ncyc || busy) && c < ncyc + 200; c++) begin
      @(negedge clk);
      if (busy && (got || held > 40)) begin
        chk(is_d ? "rand_d_done" : "rand_p_done", 64'(got), 64'd1);
        busy = 0;
        if (is_d) bus.d_req = 1'b0;
        else      bus.p_req = 1'b0;
      end
      if (!busy && c < ncyc && $urandom_range(0, 3) != 0) begin
        set_port(is_d, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
        busy = 1;
        held = 0;
      end
      @(posedge clk);
      #2;
      got = is_d ? bus.d_done : bus.p_done;
      if (busy) held++;
    end
    if (is_d) bus.d_req = 1'b0;
    else      bus.p_req = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    int          lat, st, cnt, cyc;
    bit          seen;
    logic [9:0]  ord;

    rst_n = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 64'h40, 64'hA5);
    set_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

    // Reset with a pending P store.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_p_done", 64'(bus.p_done), 64'd0);
    chk("rst_d_done", 64'(bus.d_done), 64'd0);
    chk("rst_p_rdata", bus.p_rdata, 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_p_stall", 64'(bus.p_stall), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
      seen = bus.p_done;
    end
    chk("rst_release_latency", 64'(lat), 64'd3);
    @(negedge clk);
    bus.p_req = 1'b0;

    // Store then load, with latency and stall length.
    op("st_beef", 1'b0, 1'b1, 64'h10, 64'hDEADBEEF, 0, rd, lat, st);
    chk("st_beef_latency", 64'(lat), 64'd3);
    chk("st_beef_stall", 64'(st), 64'd3);
    op("ld_beef", 1'b0, 1'b0, 64'h10, 64'h0, 0, rd, lat, st);
    chk("ld_beef_data", rd, 64'hDEADBEEF);
    chk("ld_beef_stall", 64'(st), 64'd3);

    // Alignment truncation and index wrap.
    op("st_wrap", 1'b0, 1'b1, 64'h0813, 64'd5, 0, rd, lat, st);
    op("ld_wrap", 1'b0, 1'b0, 64'h10, 64'h0, 0, rd, lat, st);
    chk("ld_wrap_data", rd, 64'd5);
    op("ld_wrap_hi", 1'b0, 1'b0, 64'hABCD_0000_0000_0815, 64'h0, 0, rd, lat, st);
    chk("ld_wrap_hi_data", rd, 64'd5);
    op("st_after_wr", 1'b0, 1'b1, 64'h10, 64'h0, 0, rd, lat, st);
    chk("st_rdata_held", rd, 64'd5);

    // D request withdrawn mid-access still completes.
    op("d_drop", 1'b1, 1'b1, 64'h18, 64'd7, 1, rd, lat, st);
    chk("d_drop_latency", 64'(lat), 64'd3);
    op("d_ld", 1'b1, 1'b0, 64'h18, 64'h0, 0, rd, lat, st);
    chk("d_ld_data", rd, 64'd7);

    // Continuous contention: P,P,P,P,D repeating.
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
    set_port(1'b1, 1'b1, 1'b1, 64'h30, 64'h33);
    cnt = 0;
    cyc = 0;
    ord = '0;
    while (cnt < 10 && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
      if (bus.p_done && cnt < 10) begin ord[cnt] = 1'b0; cnt++; end
      if (bus.d_done && cnt < 10) begin ord[cnt] = 1'b1; cnt++; end
    end
    chk("contention_count", 64'(cnt), 64'd10);
    chk("contention_order", 64'(ord), 64'(10'b1000010000));
    @(negedge clk);
    bus.p_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset during a P store's BUSY phase.
    op("st_prior", 1'b0, 1'b1, 64'h20, 64'h1111, 0, rd, lat, st);
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 64'h20, 64'd9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.p_req = 1'b0;
    seen = 0;
    repeat (2) begin @(posedge clk); #2; seen |= bus.p_done; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; seen |= bus.p_done; end
    chk("rst_busy_no_done", 64'(seen), 64'd0);
    op("ld_prior", 1'b0, 1'b0, 64'h20, 64'h0, 0, rd, lat, st);
    chk("ld_prior_data", rd, 64'h1111);

    // Randomized traffic on both ports against the model.
    repeat (2) @(negedge clk);
    fork
      drive_rand(1'b0, 1500);
      drive_rand(1'b1, 1500);
    join
    repeat (6) @(posedge clk);
    #4;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory controller for the pipelined core. It owns the 64-bit data memory array and arbitrates it between the pipeline MEM stage (port P) and a debug/loader port (port D). Each access is sequenced through a fixed multi-cycle latency, and the controller produces the pipeline stall signal. Port P has priority; a bounded-wait counter guarantees forward progress for port D.

## Interface
Parameters:
- DEPTH, 256, number of 64-bit words in the array
- AW, 8, word-index width, log2(DEPTH)
- LAT, 2, cycles spent in BUSY per access, ≥1
- MAX_WAIT, 4, consecutive P grants allowed while D is pending before D is forced

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- p_req  in  1  pipeline access request (MemRead or MemWrite in EX/MEM)
- p_we  in  1  1 = store, 0 = load
- p_addr  in  64  byte address (ALU result)
- p_wdata  in  64  store data (rs2)
- p_rdata  out  64  load data, valid when p_done=1
- p_done  out  1  one-cycle completion pulse
- p_stall  out  1  freeze IF/ID/EX/MEM registers
- d_req, d_we, d_addr[63:0], d_wdata[63:0]  in  debug/loader request, same meaning as the P fields
- d_rdata  out  64  load data, valid when d_done=1
- d_done  out  1  one-cycle completion pulse

## Operation
- Word index = addr[AW+2:3]. addr[2:0] is ignored (accesses are word-aligned by truncation). addr[63:AW+3] is ignored, so out-of-range addresses wrap.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if neither request is high, stay. Otherwise grant one port: latch owner, we, index, wdata; load the wait counter with LAT-1; go to BUSY.
  - BUSY: decrement the wait counter each cycle. On the cycle the counter reads 0, commit the access: a write updates the array, a read captures the array word into a read register. Then go to DONE.
  - DONE: pulse the owner's done for one cycle and drive the owner's rdata from the read register. Go to IDLE unconditionally. Requests are not sampled in DONE.
- Arbitration in IDLE:
  - Only one port requesting: that port wins.
  - Both ports requesting: P wins unless d_starve == MAX_WAIT, in which case D wins.
- d_starve counter:
  - +1 on each P grant made while d_req=1, saturating at MAX_WAIT.
  - Cleared on a D grant, and in any IDLE cycle where d_req=0.
- p_stall = p_req & ~p_done (combinational). The pipeline advances in the p_done cycle.
- Requesters hold req and all fields stable until done. A granted access is committed even if req drops mid-access. No abort.
- Stores write the word at the latched index; the latched fields are used, not the live inputs.
- p_rdata / d_rdata hold their last load value until the next load completes on that port. Writes return done with rdata unchanged.
- Array contents are not affected by reset.

## Timing
- Reset values: state=IDLE, counters=0, p_done=d_done=0, p_rdata=d_rdata=0. p_stall follows p_req, so it is 1 if p_req=1 during reset.
- Request seen in IDLE at edge k: BUSY for cycles k..k+LAT-1, DONE in cycle k+LAT. done is high in that cycle, i.e. LAT+1 cycles after req is first sampled.
- Minimum spacing between grants: LAT+2 cycles (IDLE, LAT×BUSY, DONE).
- A load issued immediately after a store to the same index returns the stored data, because the commit precedes the next grant.
- Reset asserted in BUSY: the access is dropped with no array write and no done. Asserted in DONE: the done pulse is cut.
- Simultaneous p_req and d_req rising in the same IDLE cycle with d_starve < MAX_WAIT: P granted and d_starve increments.

## Test plan
- Reset: hold rst_n=0 with p_req=1 → p_done=d_done=0, rdata=0, p_stall=1. Release → P is granted at the first edge.
- P store then load, LAT=2: store addr 0x10, data 0xDEADBEEF → p_done in cycle 3. Load addr 0x10 → p_rdata=0xDEADBEEF, p_stall high for exactly 3 cycles per access.
- Wrap and alignment: store 5 at addr 0x0800+0x13. Load addr 0x10 → 5 (index 2; the low bits and the bits above AW+2 are ignored).
- Contention: p_req and d_req both held high continuously → grant order is P,P,P,P,D,P,P,P,P,D… Every d_done is preceded by exactly MAX_WAIT=4 P completions.
- Req dropped mid-BUSY: D store of 7 to addr 0x18, d_req deasserted after 1 cycle → d_done still pulses and a subsequent load of 0x18 returns 7.
- Async reset mid-BUSY during a P store of 9 to addr 0x20 → no p_done, and a subsequent load of 0x20 returns the prior contents.
